// File: rtl/dmem_ctrl_pkg.sv
// Shared types and default geometry for the data-memory controller.
package dmem_ctrl_pkg;

  // Controller states: zero-fill sweep, then normal request service.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  localparam int unsigned DMEM_DW    = 12;
  localparam int unsigned DMEM_AW    = 12;
  localparam int unsigned DMEM_DEPTH = 4096;
  localparam int unsigned DMEM_BUS_W = 17;

  // Word-index width for a given depth (at least one bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_ram_2p.sv
// Plain storage array: one synchronous write port and two registered,
// read-first read ports. The array and the read registers carry no reset.
module dmem_ram_2p #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned IW    = 12
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [IW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  input  logic [IW-1:0] i_tap_addr,
  output logic [DW-1:0] o_tap_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;
  logic [DW-1:0] r_tap_data;

  // Write and both reads share one edge; non-blocking reads return pre-write contents.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
    r_tap_data <= r_mem[i_tap_addr];
  end

  assign o_rd_data  = r_rd_data;
  assign o_tap_data = r_tap_data;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: post-reset zero-fill sweep, ready/valid request
// handshake with range checking, and an always-on registered tap read port.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DW         = DMEM_DW,
  parameter int unsigned AW         = DMEM_AW,
  parameter int unsigned DEPTH      = DMEM_DEPTH,
  parameter int unsigned BUS_W      = DMEM_BUS_W,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [BUS_W-1:0] datain,
  output logic             ready,
  output logic [DW-1:0]    dataout,
  output logic             rvalid,
  output logic             err,
  input  logic [AW-1:0]    tap_addr,
  output logic [DW-1:0]    tap_data,
  output logic             init_done
);

  localparam int unsigned   IW        = idx_width(DEPTH);
  localparam logic [AW:0]   LP_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] LP_LAST   = IW'(DEPTH - 1);
  localparam state_t        LP_RST_ST = INIT_CLEAR ? ST_INIT : ST_IDLE;

  state_t        r_state;
  state_t        w_next_state;
  logic [IW-1:0] r_cnt;
  logic          r_ready;
  logic          r_rvalid;
  logic          r_err;
  logic          r_dout_ok;
  logic          r_tap_ok;

  logic          w_req_in_range;
  logic          w_tap_in_range;
  logic          w_accept;
  logic          w_wr_en;
  logic [IW-1:0] w_wr_idx;
  logic [DW-1:0] w_wr_data;
  logic          w_rd_en;
  logic [IW-1:0] w_rd_idx;
  logic [IW-1:0] w_tap_idx;
  logic [DW-1:0] w_ram_rd;
  logic [DW-1:0] w_ram_tap;

  assign w_req_in_range = {1'b0, addr} < LP_DEPTH;
  assign w_tap_in_range = {1'b0, tap_addr} < LP_DEPTH;
  // Out-of-range tap addresses are steered to word 0 so the array is never over-indexed.
  assign w_tap_idx      = w_tap_in_range ? tap_addr[IW-1:0] : '0;

  // Upper bus bits beyond the stored word are intentionally dropped.
  if (BUS_W > DW) begin : g_bus_hi
    logic w_unused_bus_hi;
    assign w_unused_bus_hi = ^datain[BUS_W-1:DW];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LP_RST_ST;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and RAM port steering: the sweep owns the write port in INIT.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_idx     = '0;
    w_wr_data    = '0;
    w_rd_en      = 1'b0;
    w_rd_idx     = '0;
    unique case (r_state)
      ST_INIT: begin
        w_wr_en  = 1'b1;
        w_wr_idx = r_cnt;
        if (r_cnt == LP_LAST) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        w_accept = req & r_ready;
        if (w_accept && w_req_in_range) begin
          if (we) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = addr[IW-1:0];
            w_wr_data = datain[DW-1:0];
          end else begin
            w_rd_en  = 1'b1;
            w_rd_idx = addr[IW-1:0];
          end
        end
      end
    endcase
  end

  // Sweep counter advances one word per INIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + IW'(1);
    end
  end

  // Handshake and response flags; dataout/tap_data select RAM data or forced zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_dout_ok <= 1'b0;
      r_tap_ok  <= 1'b0;
    end else begin
      r_ready  <= (w_next_state == ST_IDLE);
      r_rvalid <= w_accept & ~we;
      r_err    <= w_accept & ~w_req_in_range;
      if (w_accept && !we) begin
        r_dout_ok <= w_req_in_range;
      end
      r_tap_ok <= w_tap_in_range;
    end
  end

  dmem_ram_2p #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk        (clk),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (w_wr_idx),
    .i_wr_data  (w_wr_data),
    .i_rd_en    (w_rd_en),
    .i_rd_addr  (w_rd_idx),
    .o_rd_data  (w_ram_rd),
    .i_tap_addr (w_tap_idx),
    .o_tap_data (w_ram_tap)
  );

  assign ready     = r_ready;
  assign init_done = r_ready;
  assign rvalid    = r_rvalid;
  assign err       = r_err;
  assign dataout   = r_dout_ok ? w_ram_rd : '0;
  assign tap_data  = r_tap_ok ? w_ram_tap : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances cover DEPTH=16 with sweep,
// DEPTH=100 with sweep, and DEPTH=16 without sweep.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Instance A: DEPTH=16, INIT_CLEAR=1
  logic        a_rst = 1'b1, a_req = 1'b0, a_we = 1'b0;
  logic [11:0] a_addr = '0, a_tap = '0;
  logic [16:0] a_din = '0;
  logic        a_ready, a_rvalid, a_err, a_idone;
  logic [11:0] a_dout, a_tapd;

  // Instance B: DEPTH=100, INIT_CLEAR=1
  logic        b_rst = 1'b1, b_req = 1'b0, b_we = 1'b0;
  logic [11:0] b_addr = '0, b_tap = '0;
  logic [16:0] b_din = '0;
  logic        b_ready, b_rvalid, b_err, b_idone;
  logic [11:0] b_dout, b_tapd;

  // Instance C: DEPTH=16, INIT_CLEAR=0, idle inputs
  logic        c_rst = 1'b1, c_req = 1'b0, c_we = 1'b0;
  logic [11:0] c_addr = '0, c_tap = '0;
  logic [16:0] c_din = '0;
  logic        c_ready, c_rvalid, c_err, c_idone;
  logic [11:0] c_dout, c_tapd;

  dmem_ctrl #(.DW(12), .AW(12), .DEPTH(16), .BUS_W(17), .INIT_CLEAR(1'b1)) u_a (
    .clk(clk), .rst(a_rst), .req(a_req), .we(a_we), .addr(a_addr), .datain(a_din),
    .ready(a_ready), .dataout(a_dout), .rvalid(a_rvalid), .err(a_err),
    .tap_addr(a_tap), .tap_data(a_tapd), .init_done(a_idone));

  dmem_ctrl #(.DW(12), .AW(12), .DEPTH(100), .BUS_W(17), .INIT_CLEAR(1'b1)) u_b (
    .clk(clk), .rst(b_rst), .req(b_req), .we(b_we), .addr(b_addr), .datain(b_din),
    .ready(b_ready), .dataout(b_dout), .rvalid(b_rvalid), .err(b_err),
    .tap_addr(b_tap), .tap_data(b_tapd), .init_done(b_idone));

  dmem_ctrl #(.DW(12), .AW(12), .DEPTH(16), .BUS_W(17), .INIT_CLEAR(1'b0)) u_c (
    .clk(clk), .rst(c_rst), .req(c_req), .we(c_we), .addr(c_addr), .datain(c_din),
    .ready(c_ready), .dataout(c_dout), .rvalid(c_rvalid), .err(c_err),
    .tap_addr(c_tap), .tap_data(c_tapd), .init_done(c_idone));

  // One request on A, accepted at the next edge; returns at edge+1.
  task automatic a_op(input logic w, input logic [11:0] ad, input logic [16:0] d);
    a_req = 1'b1; a_we = w; a_addr = ad; a_din = d;
    @(posedge clk); #1;
    a_req = 1'b0; a_we = 1'b0;
  endtask

  task automatic b_op(input logic w, input logic [11:0] ad, input logic [16:0] d);
    b_req = 1'b1; b_we = w; b_addr = ad; b_din = d;
    @(posedge clk); #1;
    b_req = 1'b0; b_we = 1'b0;
  endtask

  task automatic a_wait_ready(output int n);
    n = 0;
    while (a_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic b_wait_ready(output int n);
    n = 0;
    while (b_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    #1;
    n_total++; if (a_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", a_ready); else n_pass++;
    n_total++; if (a_dout !== 12'h000) $display("FAIL rst_dout got=%h exp=000", a_dout); else n_pass++;
    n_total++; if ({a_rvalid, a_err} !== 2'b00) $display("FAIL rst_rvalid_err got=%b exp=00", {a_rvalid, a_err}); else n_pass++;
    n_total++; if ({a_tapd, a_idone} !== 13'h0) $display("FAIL rst_tap_idone got=%h exp=0", {a_tapd, a_idone}); else n_pass++;
    n_total++; if (c_ready !== 1'b0) $display("FAIL rst_c_ready got=%b exp=0", c_ready); else n_pass++;
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    n = 0;
    while (a_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        n_total++; if ({c_ready, c_idone} !== 2'b11) $display("FAIL noclear_first_edge got=%b exp=11", {c_ready, c_idone}); else n_pass++;
      end
    end
    n_total++; if (n != 16) $display("FAIL sweep_cycles got=%0d exp=16", n); else n_pass++;
    n_total++; if (a_idone !== 1'b1) $display("FAIL sweep_init_done got=%b exp=1", a_idone); else n_pass++;
  endtask

  task automatic test_sweep_clear;
    int n;
    a_op(1'b1, 12'd5, 17'h00ABC);
    a_op(1'b0, 12'd5, 17'h0);
    n_total++; if (a_dout !== 12'hABC) $display("FAIL poke_read got=%h exp=abc", a_dout); else n_pass++;
    a_rst = 1'b1; #1; a_rst = 1'b0;
    a_wait_ready(n);
    n_total++; if (n != 16) $display("FAIL resweep_cycles got=%0d exp=16", n); else n_pass++;
    a_op(1'b0, 12'd5, 17'h0);
    n_total++; if ({a_rvalid, a_dout} !== 13'h1000) $display("FAIL cleared_word5 got=%h exp=1000", {a_rvalid, a_dout}); else n_pass++;
  endtask

  task automatic test_write_read;
    a_op(1'b1, 12'd4, 17'h1F001);
    n_total++; if (a_rvalid !== 1'b0) $display("FAIL write_no_rvalid got=%b exp=0", a_rvalid); else n_pass++;
    n_total++; if (a_dout !== 12'h000) $display("FAIL write_dout_hold got=%h exp=000", a_dout); else n_pass++;
    a_op(1'b0, 12'd4, 17'h0);
    n_total++; if ({a_rvalid, a_dout} !== 13'h1001) $display("FAIL read4 got=%h exp=1001", {a_rvalid, a_dout}); else n_pass++;
    @(posedge clk); #1;
    n_total++; if ({a_rvalid, a_dout} !== 13'h0001) $display("FAIL read4_after got=%h exp=0001", {a_rvalid, a_dout}); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n;
    logic [11:0] ad [4];
    logic [11:0] ex [4];
    ad = '{12'd4, 12'd5, 12'd68, 12'd69};
    ex = '{12'd1, 12'd2, 12'd3, 12'd4};
    b_wait_ready(n);
    n_total++; if (b_ready !== 1'b1) $display("FAIL b_ready got=%b exp=1 after %0d cycles", b_ready, n); else n_pass++;
    for (int i = 0; i < 4; i++) b_op(1'b1, ad[i], {5'h0, ex[i]});
    b_req = 1'b1; b_we = 1'b0; b_addr = ad[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) b_addr = ad[i+1]; else b_req = 1'b0;
      n_total++;
      if ({b_rvalid, b_dout} !== {1'b1, ex[i]})
        $display("FAIL b2b_read%0d got=%h exp=%h", i, {b_rvalid, b_dout}, {1'b1, ex[i]});
      else n_pass++;
    end
    @(posedge clk); #1;
    n_total++; if (b_rvalid !== 1'b0) $display("FAIL b2b_end got=%b exp=0", b_rvalid); else n_pass++;
  endtask

  task automatic test_out_of_range;
    b_op(1'b1, 12'd99, 17'h00055);
    b_op(1'b1, 12'd100, 17'h00007);
    n_total++; if ({b_err, b_rvalid} !== 2'b10) $display("FAIL oor_write got=%b exp=10", {b_err, b_rvalid}); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (b_err !== 1'b0) $display("FAIL oor_err_pulse got=%b exp=0", b_err); else n_pass++;
    b_op(1'b0, 12'd100, 17'h0);
    n_total++; if ({b_err, b_rvalid, b_dout} !== 14'h3000) $display("FAIL oor_read got=%h exp=3000", {b_err, b_rvalid, b_dout}); else n_pass++;
    b_op(1'b0, 12'd99, 17'h0);
    n_total++; if ({b_err, b_rvalid, b_dout} !== 14'h1055) $display("FAIL word99 got=%h exp=1055", {b_err, b_rvalid, b_dout}); else n_pass++;
  endtask

  task automatic test_tap_collision;
    a_op(1'b1, 12'd3, 17'h00009);
    a_tap = 12'd3;
    a_op(1'b1, 12'd3, 17'h00006);
    n_total++; if (a_tapd !== 12'h009) $display("FAIL tap_read_first got=%h exp=009", a_tapd); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (a_tapd !== 12'h006) $display("FAIL tap_new got=%h exp=006", a_tapd); else n_pass++;
    a_tap = 12'd20;
    @(posedge clk); #1;
    n_total++; if ({a_ready, a_tapd} !== 13'h1000) $display("FAIL tap_oor got=%h exp=1000", {a_ready, a_tapd}); else n_pass++;
    a_tap = 12'd0;
  endtask

  task automatic test_reset_mid_read;
    int n;
    a_op(1'b1, 12'd4, 17'h000AA);
    a_op(1'b0, 12'd4, 17'h0);
    n_total++; if ({a_rvalid, a_dout} !== 13'h10AA) $display("FAIL midread_pre got=%h exp=10aa", {a_rvalid, a_dout}); else n_pass++;
    a_rst = 1'b1; #1;
    n_total++; if ({a_ready, a_rvalid, a_dout} !== 14'h0) $display("FAIL midread_rst got=%h exp=0000", {a_ready, a_rvalid, a_dout}); else n_pass++;
    a_rst = 1'b0;
    a_wait_ready(n);
    n_total++; if (n != 16) $display("FAIL midread_sweep got=%0d exp=16", n); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    a_rst = 1'b1; #1; a_rst = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    n_total++; if (a_ready !== 1'b0) $display("FAIL midsweep_busy got=%b exp=0", a_ready); else n_pass++;
    a_rst = 1'b1; #1; a_rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    a_req = 1'b1; a_we = 1'b1; a_addr = 12'd2; a_din = 17'h00777;
    @(posedge clk); #1;
    a_req = 1'b0; a_we = 1'b0;
    n_total++; if ({a_ready, a_rvalid, a_err} !== 3'b000) $display("FAIL init_req_ignored got=%b exp=000", {a_ready, a_rvalid, a_err}); else n_pass++;
    a_wait_ready(n);
    n_total++; if (n != 10) $display("FAIL restart_cycles got=%0d exp=10", n); else n_pass++;
    a_op(1'b0, 12'd2, 17'h0);
    n_total++; if ({a_rvalid, a_dout} !== 13'h1000) $display("FAIL init_write_lost got=%h exp=1000", {a_rvalid, a_dout}); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_sweep_clear;
    test_write_read;
    test_back_to_back;
    test_out_of_range;
    test_tap_collision;
    test_reset_mid_read;
    test_reset_mid_sweep;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
